scoreboard_register_file: RTL
=============================

SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, register width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 8, number of registers (2..32).
REQ-003 The block SHALL have parameter SEL_WIDTH, default 3, selector width (= ceil(log2(NUM_REGS))).
REQ-004 The block SHALL have parameter ZERO_REG, default 0; 1 = register 0 reads zero, ignores writes, is never busy.
REQ-005 The block SHALL have parameter BYPASS, default 1; 1 = same-cycle write data forwarded to read ports.
REQ-006 The block SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-007 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 The block SHALL have port src1_bus_selector  input  SEL_WIDTH  read port 1 register index.
REQ-009 The block SHALL have port src2_bus_selector  input  SEL_WIDTH  read port 2 register index.
REQ-010 The block SHALL have port src1  output  DATA_WIDTH  read port 1 data.
REQ-011 The block SHALL have port src2  output  DATA_WIDTH  read port 2 data.
REQ-012 The block SHALL have port wr_en  input  1  write strobe.
REQ-013 The block SHALL have port dest_bus_selector  input  SEL_WIDTH  write register index.
REQ-014 The block SHALL have port data  input  DATA_WIDTH  write data.
REQ-015 The block SHALL have port issue_en  input  1  request to reserve a destination register for a pending result.
REQ-016 The block SHALL have port issue_sel  input  SEL_WIDTH  register to reserve.
REQ-017 The block SHALL have ports src1_busy / src2_busy  output  1 each  selected source has a pending result.
REQ-018 The block SHALL have port stall  output  1  issue request refused this cycle.

Function
REQ-019 Reads SHALL be combinational, zero latency: srcN = reg[srcN_bus_selector].
REQ-020 Write: at rising edge with wr_en=1, reg[dest_bus_selector] <= data; visible on reads the following cycle.
REQ-021 BYPASS=1 and wr_en=1 and dest_bus_selector==srcN_bus_selector: srcN SHALL equal data in the same cycle.
REQ-022 Selector >= NUM_REGS: read returns 0, busy reads 0, write and issue ignored.
REQ-023 ZERO_REG=1: selector 0 reads 0 on both ports (no bypass), writes to 0 dropped, issue to 0 never sets busy and never stalls.
REQ-024 Scoreboard: one busy bit per register; set at edge when issue_en=1, stall=0, valid issue_sel.
REQ-025 busy[i] SHALL clear at edge when wr_en=1 and dest_bus_selector==i.
REQ-026 Simultaneous accepted issue and write to the same register: busy SHALL remain 1 (new reservation wins); data still written.
REQ-027 srcN_busy = busy[srcN_bus_selector], masked to 0 when BYPASS=1 and the same-cycle write targets that register.
REQ-028 stall = issue_en & (src1_busy | src2_busy | busy[issue_sel] not cleared this cycle); combinational.
REQ-029 A stalled issue SHALL change no state; requester holds issue_en/selectors until stall=0.
REQ-030 Writes SHALL be accepted regardless of busy state or stall.

Reset
REQ-031 reset=0 SHALL asynchronously clear all registers to 0 and all busy bits to 0, including mid-operation.
REQ-032 During reset: src1=src2=0, src1_busy=src2_busy=0; stall follows REQ-028 with busy=0 (0 unless issue_en with nothing busy -> 0).
REQ-033 Writes and issues presented while reset=0 SHALL be ignored; first effective edge is the first rising edge with reset=1.

Structure
REQ-034 Register selector codes (R0_SELECTOR..R7_SELECTOR) and default DATA_WIDTH/NUM_REGS SHALL live in the shared parameters include.
REQ-035 Busy-bit logic SHALL be a sub-module register_scoreboard (ports: clk, reset, issue, clear, query selectors, busy outputs); storage and bypass stay in the top.

Verification
REQ-036 Reset then wr_en=1, dest=R0, data=8'hFF, one edge; src1_sel=R0 -> src1=8'hFF (ZERO_REG=0); with ZERO_REG=1 -> src1=8'h00.
REQ-037 BYPASS=1: wr_en=1, dest=R3, data=8'hA5, src1_sel=R3 in same cycle -> src1=8'hA5 before the edge; BYPASS=0 -> old value 8'h00.
REQ-038 issue_en=1, issue_sel=R6 -> next cycle src2_sel=R6 gives src2_busy=1; issue to R2 with src1_sel=R6 -> stall=1, busy[2] stays 0; write R6=8'h3C -> busy clears, stall drops.
REQ-039 Same edge: issue R4 accepted and wr_en to R4 with 8'h11 -> R4=8'h11, busy[4]=1.
REQ-040 NUM_REGS=6, DATA_WIDTH=16: write selector 7 data 16'hBEEF -> reads of selector 7 give 0, registers 0..5 unchanged.
REQ-041 Set busy on R1,R5 and registers nonzero, assert reset=0 between edges -> outputs and busy clear immediately, no clock needed.

Source files
------------

// File: rtl/scoreboard_register_file_pkg.sv
// Shared defaults and register selector codes for the scoreboarded register file.
package scoreboard_register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_NUM_REGS   = 8;
  localparam int DEFAULT_SEL_WIDTH  = 3;

  localparam logic [2:0] R0_SELECTOR = 3'd0;
  localparam logic [2:0] R1_SELECTOR = 3'd1;
  localparam logic [2:0] R2_SELECTOR = 3'd2;
  localparam logic [2:0] R3_SELECTOR = 3'd3;
  localparam logic [2:0] R4_SELECTOR = 3'd4;
  localparam logic [2:0] R5_SELECTOR = 3'd5;
  localparam logic [2:0] R6_SELECTOR = 3'd6;
  localparam logic [2:0] R7_SELECTOR = 3'd7;

endpackage

// File: rtl/scoreboard_register_file_scoreboard.sv
// Busy-bit scoreboard: one pending-result flag per register, set by accepted
// issues and cleared by writes; a reservation wins over a same-edge clear.
module register_scoreboard
  import scoreboard_register_file_pkg::*;
#(
  parameter int NUM_REGS  = DEFAULT_NUM_REGS,
  parameter int SEL_WIDTH = DEFAULT_SEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_issueEn,
  input  logic [SEL_WIDTH-1:0] i_issueSel,
  input  logic                 i_clearEn,
  input  logic [SEL_WIDTH-1:0] i_clearSel,
  input  logic [SEL_WIDTH-1:0] i_query1Sel,
  input  logic [SEL_WIDTH-1:0] i_query2Sel,
  input  logic [SEL_WIDTH-1:0] i_query3Sel,
  output logic                 o_busy1,
  output logic                 o_busy2,
  output logic                 o_busy3
);

  logic [NUM_REGS-1:0] r_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_issueEn && int'(i_issueSel) == i) begin
          r_busy[i] <= 1'b1;
        end else if (i_clearEn && int'(i_clearSel) == i) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Out-of-range selectors never report busy.
  always_comb begin
    o_busy1 = 1'b0;
    o_busy2 = 1'b0;
    o_busy3 = 1'b0;
    if (int'(i_query1Sel) < NUM_REGS) o_busy1 = r_busy[i_query1Sel];
    if (int'(i_query2Sel) < NUM_REGS) o_busy2 = r_busy[i_query2Sel];
    if (int'(i_query3Sel) < NUM_REGS) o_busy3 = r_busy[i_query3Sel];
  end

endmodule

// File: rtl/scoreboard_register_file.sv
// Two-read/one-write register file with optional write bypass and a busy-bit
// scoreboard that refuses issues whose sources or destination are pending.
module scoreboard_register_file
  import scoreboard_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int SEL_WIDTH  = DEFAULT_SEL_WIDTH,
  parameter bit ZERO_REG   = 1'b0,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_WIDTH-1:0]  src1_bus_selector,
  input  logic [SEL_WIDTH-1:0]  src2_bus_selector,
  output logic [DATA_WIDTH-1:0] src1,
  output logic [DATA_WIDTH-1:0] src2,
  input  logic                  wr_en,
  input  logic [SEL_WIDTH-1:0]  dest_bus_selector,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  issue_en,
  input  logic [SEL_WIDTH-1:0]  issue_sel,
  output logic                  src1_busy,
  output logic                  src2_busy,
  output logic                  stall
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic w_wrValid;
  logic w_src1Fwd;
  logic w_src2Fwd;
  logic w_busy1Raw;
  logic w_busy2Raw;
  logic w_busyIssueRaw;
  logic w_issueCleared;
  logic w_issueExempt;
  logic w_issueAccept;

  // A selector is usable when in range and not the hardwired zero register.
  function automatic logic selValid(input logic [SEL_WIDTH-1:0] sel);
    return (int'(sel) < NUM_REGS) && !(ZERO_REG && sel == '0);
  endfunction

  assign w_wrValid = wr_en && reset && selValid(dest_bus_selector);
  assign w_src1Fwd = BYPASS && w_wrValid && (dest_bus_selector == src1_bus_selector);
  assign w_src2Fwd = BYPASS && w_wrValid && (dest_bus_selector == src2_bus_selector);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wrValid) begin
      r_regs[dest_bus_selector] <= data;
    end
  end

  always_comb begin
    src1 = '0;
    src2 = '0;
    if (selValid(src1_bus_selector)) src1 = w_src1Fwd ? data : r_regs[src1_bus_selector];
    if (selValid(src2_bus_selector)) src2 = w_src2Fwd ? data : r_regs[src2_bus_selector];
  end

  register_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .i_issueEn   (w_issueAccept),
    .i_issueSel  (issue_sel),
    .i_clearEn   (w_wrValid),
    .i_clearSel  (dest_bus_selector),
    .i_query1Sel (src1_bus_selector),
    .i_query2Sel (src2_bus_selector),
    .i_query3Sel (issue_sel),
    .o_busy1     (w_busy1Raw),
    .o_busy2     (w_busy2Raw),
    .o_busy3     (w_busyIssueRaw)
  );

  // A write landing this cycle resolves the hazard, so it unblocks the issue.
  assign src1_busy      = w_busy1Raw && !w_src1Fwd;
  assign src2_busy      = w_busy2Raw && !w_src2Fwd;
  assign w_issueCleared = w_wrValid && (dest_bus_selector == issue_sel);
  assign w_issueExempt  = ZERO_REG && (issue_sel == '0);
  assign stall          = issue_en && !w_issueExempt &&
                          (src1_busy || src2_busy || (w_busyIssueRaw && !w_issueCleared));
  assign w_issueAccept  = issue_en && !stall && reset && selValid(issue_sel);

endmodule
